regfile_write_scheduler: RTL and testbench
==========================================

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 SHALL have parameter n, default 64, data width of the register file write port.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  write-back request from requester 0 (ALU) / 1 (memory load).
REQ-005 SHALL have ports req0_addr/req1_addr  input  5 each  destination register index.
REQ-006 SHALL have ports req0_data/req1_data  input  n each  write-back data.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1 each  handshake accept, combinational.
REQ-008 SHALL have ports reserve_valid  input  1, reserve_addr  input  5, reserve_ready  output  1  issue-stage destination reservation.
REQ-009 SHALL have ports select_a/select_b  input  5 each, hazard_a/hazard_b  output  1 each  read-operand pending-write query.
REQ-010 SHALL have ports write  output  1, address  output  5, data_in  output  n  registered drive of the register file write port.
REQ-011 SHALL have port busy_count  output  6  number of registers with a pending write.

Function
REQ-012 SHALL complete a request handshake in a cycle where reqX_valid and reqX_ready are both 1.
REQ-013 SHALL grant at most one requester per cycle; reqX_ready SHALL be 0 when reqX_valid is 0.
REQ-014 SHALL grant the sole valid requester when only one is valid.
REQ-015 SHALL, when both are valid, grant the requester not granted most recently; priority pointer SHALL update only on a completed handshake.
REQ-016 SHALL register the granted request so write=1, address, data_in appear in the cycle after the handshake (latency 1); write SHALL be 0 in cycles following no handshake.
REQ-017 SHALL accept a handshake to address 31 (hardwired zero) but keep write=0 for it and never mark register 31 busy.
REQ-018 SHALL hold a 31-bit busy vector; a reservation completes when reserve_valid and reserve_ready are both 1 and sets busy[reserve_addr] at that edge.
REQ-019 SHALL drive reserve_ready = 0 when busy[reserve_addr] is 1, else 1; reserve_addr 31 SHALL always be ready and set nothing.
REQ-020 SHALL clear busy[address] at the edge ending a cycle with write=1 (same edge the register file captures data).
REQ-021 SHALL, when a set and a clear target the same index at the same edge, leave the bit set.
REQ-022 SHALL drive hazard_a = busy[select_a], hazard_b = busy[select_b], combinational from registered state; select 31 SHALL give 0.
REQ-023 SHALL drive busy_count as the population count of the busy vector (0..31).
REQ-024 SHALL perform a write-back to a non-busy register normally (no error, busy unchanged).

Reset
REQ-025 SHALL, while reset=1 at an edge, clear busy vector, set priority pointer to requester 0, and load write=0, address=0, data_in=0.
REQ-026 SHALL drop any registered pending write when reset is asserted mid-operation; req ready outputs SHALL be 0 and reserve_ready SHALL be 1 during reset cycles.
REQ-027 SHALL produce busy_count=0, hazard_a=0, hazard_b=0 in the first cycle after reset.

Structure
REQ-028 SHALL take REG_COUNT=32, ADDR_W=5, ZERO_REG=5'd31 from a shared package regfile_pkg.
REQ-029 SHALL implement arbitration in one sub-module rr_arbiter_2 (two-way round-robin, pointer state inside it).
REQ-030 SHALL contain no register-file storage; it drives the existing register file write port only.

Verification
REQ-031 Reserve r5, then req0 addr 5 data 0xDEAD -> req0_ready=1, next cycle write=1 address=5 data_in=0xDEAD; hazard on select_a=5 is 1 until two cycles after handshake, then 0.
REQ-032 Both valid for 4 cycles (req0 addr 1, req1 addr 2) after reset -> grants in order 0,1,0,1; writes appear one cycle later in the same order.
REQ-033 req1 addr 31 data 0xFFFF -> req1_ready=1, write stays 0, busy_count unchanged.
REQ-034 Reserve r7 while busy[7]=1 -> reserve_ready=0; same cycle as write to r7 with reserve r7 -> busy[7] remains 1.
REQ-035 Reserve r3,r4, handshake req0 addr 3, assert reset the next cycle -> write=0, busy_count=0, priority back to requester 0.
REQ-036 Reserve all of r0..r30 over 31 cycles -> busy_count=31, reserve_ready=0 for any of r0..r30, 1 for r31.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants for the write-back scheduler.
//   REG_COUNT : architectural registers, including the hardwired-zero one
//   ADDR_W    : register index width
//   ZERO_REG  : index of the hardwired-zero register (never written, never busy)
//   req_id_e  : identifies a write-back requester (ALU or memory load)
package regfile_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic {
    ReqAlu = 1'b0,
    ReqMem = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. When both requesters are valid the one not
// granted most recently wins; the pointer moves only on a completed grant.
// Grants are forced low while reset is high.
//   clock, reset   : clock and synchronous active-high reset
//   valid0, valid1 : request lines
//   grant0, grant1 : one-hot-or-zero grants (combinational)
module rr_arbiter_2
  import regfile_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  // Requester favoured on the next contended cycle.
  req_id_e prio_q, prio_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    prio_d = prio_q;
    if (!reset) begin
      grant0 = valid0 && (!valid1 || (prio_q == ReqAlu));
      grant1 = valid1 && (!valid0 || (prio_q == ReqMem));
    end
    if (grant0) begin
      prio_d = ReqMem;
    end else if (grant1) begin
      prio_d = ReqAlu;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q <= ReqAlu;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Write-back scheduler for the register file write port. Arbitrates between
// the ALU and the memory-load write-back paths, tracks destinations reserved
// by the issue stage (busy vector) and answers read-operand hazard queries.
//   clock, reset                      : clock, synchronous active-high reset
//   req{0,1}_valid/addr/data/ready    : write-back request handshakes
//   reserve_valid/addr/ready          : issue-stage destination reservation
//   select_{a,b}, hazard_{a,b}        : pending-write query per read operand
//   write, address, data_in           : registered register-file write port
//   busy_count                        : number of registers awaiting a write
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned n = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [n-1:0]      req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [n-1:0]      req1_data,
  output logic              req1_ready,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              reserve_ready,
  input  logic [ADDR_W-1:0] select_a,
  input  logic [ADDR_W-1:0] select_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [n-1:0]      data_in,
  output logic [5:0]        busy_count
);

  logic                   write_q, write_d;
  logic [ADDR_W-1:0]      address_q, address_d;
  logic [n-1:0]           data_q, data_d;
  logic [REG_COUNT-2:0]   busy_q, busy_d;
  // Busy vector padded with a constant-zero bit for the hardwired-zero
  // register, so any 5-bit index reads it without a special case.
  logic [REG_COUNT-1:0]   busy_ext;
  logic [REG_COUNT-1:0]   set_ext, clr_ext;

  rr_arbiter_2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (req0_ready),
    .grant1 (req1_ready)
  );

  assign busy_ext      = {1'b0, busy_q};
  assign reserve_ready = reset | ~busy_ext[reserve_addr];
  assign hazard_a      = busy_ext[select_a];
  assign hazard_b      = busy_ext[select_b];

  always_comb begin
    write_d   = 1'b0;
    address_d = address_q;
    data_d    = data_q;
    if (req0_ready) begin
      write_d   = (req0_addr != ZERO_REG);
      address_d = req0_addr;
      data_d    = req0_data;
    end else if (req1_ready) begin
      write_d   = (req1_addr != ZERO_REG);
      address_d = req1_addr;
      data_d    = req1_data;
    end
  end

  // Set is applied after clear so a same-edge reservation wins.
  always_comb begin
    set_ext = '0;
    clr_ext = '0;
    if (reserve_valid && reserve_ready) begin
      set_ext = REG_COUNT'(1) << reserve_addr;
    end
    if (write_q) begin
      clr_ext = REG_COUNT'(1) << address_q;
    end
    busy_d = (busy_q & ~clr_ext[REG_COUNT-2:0]) | set_ext[REG_COUNT-2:0];
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < REG_COUNT - 1; i++) begin
      busy_count = busy_count + 6'(busy_q[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_q   <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      busy_q    <= '0;
    end else begin
      write_q   <= write_d;
      address_q <= address_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  assign write   = write_q;
  assign address = address_q;
  assign data_in = data_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with a set-based reference model
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_regfile_write_scheduler;

  localparam int N = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, reserve_valid;
  logic [4:0]    req0_addr, req1_addr, reserve_addr, select_a, select_b;
  logic [N-1:0]  req0_data, req1_data;
  logic          req0_ready, req1_ready, reserve_ready, hazard_a, hazard_b, write;
  logic [4:0]    address;
  logic [N-1:0]  data_in;
  logic [5:0]    busy_count;

  regfile_write_scheduler #(.n(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .reserve_ready (reserve_ready),
    .select_a      (select_a),
    .select_b      (select_b),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b),
    .write         (write),
    .address       (address),
    .data_in       (data_in),
    .busy_count    (busy_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: set of registers awaiting a write, the write scheduled
  // for the next cycle, and which requester won most recently.
  bit           m_busy [32];
  int           m_last;
  bit           m_write;
  logic [4:0]   m_addr;
  logic [N-1:0] m_data;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_grant0();
    return !reset && req0_valid && (!req1_valid || m_last != 0);
  endfunction

  function automatic bit exp_grant1();
    return !reset && req1_valid && (!req0_valid || m_last != 1);
  endfunction

  function automatic bit is_busy(input logic [4:0] r);
    return (r != 5'd31) && m_busy[r];
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic compare_all();
    chk("req0_ready", N'(req0_ready), N'(exp_grant0()));
    chk("req1_ready", N'(req1_ready), N'(exp_grant1()));
    chk("write", N'(write), N'(m_write));
    if (m_write) begin
      chk("address", N'(address), N'(m_addr));
      chk("data_in", data_in, m_data);
    end
    chk("busy_count", N'(busy_count), N'(model_count()));
    chk("hazard_a", N'(hazard_a), N'(is_busy(select_a)));
    chk("hazard_b", N'(hazard_b), N'(is_busy(select_b)));
    chk("reserve_ready", N'(reserve_ready), N'(reset || !is_busy(reserve_addr)));
  endtask

  task automatic model_update();
    bit g0, g1, res_ok;
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_last  = 1;
      m_write = 1'b0;
      m_addr  = '0;
      m_data  = '0;
    end else begin
      g0     = exp_grant0();
      g1     = exp_grant1();
      res_ok = reserve_valid && !is_busy(reserve_addr);
      if (m_write) m_busy[m_addr] = 1'b0;
      if (res_ok && reserve_addr != 5'd31) m_busy[reserve_addr] = 1'b1;
      m_write = 1'b0;
      if (g0) begin
        m_write = (req0_addr != 5'd31);
        m_addr  = req0_addr;
        m_data  = req0_data;
        m_last  = 0;
      end else if (g1) begin
        m_write = (req1_addr != 5'd31);
        m_addr  = req1_addr;
        m_data  = req1_data;
        m_last  = 1;
      end
    end
  endtask

  // One cycle: compare mid-cycle, advance the model at the edge, then let the
  // caller change inputs just after the edge.
  task automatic step();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    model_update();
    #1;
  endtask

  int order;

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; reserve_valid = 0;
    req0_addr = 0; req1_addr = 0; reserve_addr = 0;
    req0_data = 0; req1_data = 0;
    select_a = 5'd5; select_b = 5'd7;
    m_last = 1; m_write = 0; m_addr = 0; m_data = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;

    step();
    step();
    reset = 1'b0;
    #1;
    chk("post_reset_write", N'(write), N'(0));
    chk("post_reset_address", N'(address), N'(0));
    chk("post_reset_data", data_in, N'(0));
    chk("post_reset_count", N'(busy_count), N'(0));
    chk("post_reset_hazard_a", N'(hazard_a), N'(0));
    step();

    // Reserve r5, then write it back from the ALU.
    reserve_valid = 1; reserve_addr = 5'd5;
    step();
    reserve_valid = 0;
    req0_valid = 1; req0_addr = 5'd5; req0_data = N'(64'hDEAD);
    #1;
    chk("r5_req0_ready", N'(req0_ready), N'(1));
    chk("r5_hazard_hs", N'(hazard_a), N'(1));
    step();
    req0_valid = 0;
    #1;
    chk("r5_write", N'(write), N'(1));
    chk("r5_address", N'(address), N'(5));
    chk("r5_data", data_in, N'(64'hDEAD));
    chk("r5_hazard_wb", N'(hazard_a), N'(1));
    step();
    #1;
    chk("r5_hazard_clear", N'(hazard_a), N'(0));
    chk("r5_write_done", N'(write), N'(0));
    step();

    // Contended requests alternate starting with requester 0.
    reset = 1;
    step();
    reset = 0;
    req0_valid = 1; req0_addr = 5'd1; req0_data = N'(64'h11);
    req1_valid = 1; req1_addr = 5'd2; req1_data = N'(64'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      order = req1_ready ? 1 : 0;
      chk("rr_order", N'(order), N'(i % 2));
      if (i > 0) begin
        chk("rr_write", N'(write), N'(1));
        chk("rr_address", N'(address), N'((i % 2 == 1) ? 1 : 2));
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("rr_last_address", N'(address), N'(2));
    step();

    // Write-back to the hardwired-zero register, plus a reservation of it.
    req1_valid = 1; req1_addr = 5'd31; req1_data = N'(64'hFFFF);
    reserve_valid = 1; reserve_addr = 5'd31;
    #1;
    chk("zero_req1_ready", N'(req1_ready), N'(1));
    chk("zero_reserve_ready", N'(reserve_ready), N'(1));
    step();
    req1_valid = 0; reserve_valid = 0;
    #1;
    chk("zero_write", N'(write), N'(0));
    chk("zero_count", N'(busy_count), N'(0));
    step();

    // Reserve r7, then it blocks a second reservation.
    reserve_valid = 1; reserve_addr = 5'd7;
    step();
    #1;
    chk("r7_blocked", N'(reserve_ready), N'(0));
    req0_valid = 1; req0_addr = 5'd7; req0_data = N'(64'h77);
    step();
    reserve_valid = 0; req0_valid = 0;
    step();
    #1;
    chk("r7_cleared", N'(hazard_b), N'(0));
    // Non-busy write-back to r7 with a same-edge reservation: set wins.
    req0_valid = 1; req0_addr = 5'd7; req0_data = N'(64'h78);
    step();
    req0_valid = 0;
    reserve_valid = 1; reserve_addr = 5'd7;
    #1;
    chk("r7_collide_write", N'(write), N'(1));
    chk("r7_collide_ready", N'(reserve_ready), N'(1));
    step();
    reserve_valid = 0;
    #1;
    chk("r7_set_wins", N'(hazard_b), N'(1));
    step();

    // Reset mid-operation drops the pending write and the busy state.
    reserve_valid = 1; reserve_addr = 5'd3;
    step();
    reserve_addr = 5'd4;
    step();
    reserve_valid = 0;
    req0_valid = 1; req0_addr = 5'd3; req0_data = N'(64'h33);
    step();
    req0_valid = 0;
    reset = 1; reserve_addr = 5'd3;
    #1;
    chk("reset_reserve_ready", N'(reserve_ready), N'(1));
    step();
    reset = 0;
    #1;
    chk("reset_write", N'(write), N'(0));
    chk("reset_count", N'(busy_count), N'(0));
    req0_valid = 1; req0_addr = 5'd8; req1_valid = 1; req1_addr = 5'd9;
    #1;
    chk("reset_prio0", N'(req0_ready), N'(1));
    chk("reset_prio1", N'(req1_ready), N'(0));
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    step();

    // Fill every writable register.
    for (int i = 0; i < 31; i++) begin
      reserve_valid = 1; reserve_addr = 5'(i);
      step();
    end
    reserve_valid = 0;
    #1;
    chk("full_count", N'(busy_count), N'(31));
    for (int i = 0; i < 32; i++) begin
      reserve_addr = 5'(i);
      #1;
      chk("full_reserve_ready", N'(reserve_ready), N'(i == 31));
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
